// File: rtl/timer_share_ctrl.sv
// timer_share_ctrl: shares one APB timer slave between NUM_REQ requesters.
// Round-robin arbitration, APB programming of the timer, and completion signalling.
//
// Ports:
//   HCLK, HRESETn       clock, asynchronous active-low reset
//   req_i/cmp_i/presc_i per-requester level request, compare value, prescaler
//   gnt_o/done_o/err_o  one-hot grant, completion pulse, reject pulse
//   busy_o              high whenever the FSM is not in IDLE
//   PADDR..PREADY       APB master port (writes only)
//   timer_irq_i         timer interrupts; bit1 = compare match

module timer_share_ctrl #(
    parameter int                        NUM_REQ        = 4,
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] TIMER_BASE     = '0
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*32-1:0]       cmp_i,
    input  logic [NUM_REQ*3-1:0]        presc_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [NUM_REQ-1:0]          err_o,
    output logic                        busy_o,
    output logic [APB_ADDR_WIDTH-1:0]   PADDR,
    output logic [31:0]                 PWDATA,
    output logic                        PWRITE,
    output logic                        PSEL,
    output logic                        PENABLE,
    input  logic                        PREADY,
    input  logic [1:0]                  timer_irq_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL =
        TIMER_BASE + APB_ADDR_WIDTH'(4);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CMP =
        TIMER_BASE + APB_ADDR_WIDTH'(8);

    typedef enum logic [2:0] {
        S_IDLE, S_DIS, S_CMP, S_EN, S_WAIT, S_STOP, S_DONE, S_ERR
    } state_t;

    // GAP: PSEL low inside a write state; SETUP/ACC: the two APB phases
    typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACC} phase_t;

    state_t                      state_q;
    phase_t                      phase_q;
    logic [IW-1:0]               ptr_q;
    logic [IW-1:0]               idx_q;
    logic [31:0]                 cmp_q;
    logic [2:0]                  presc_q;
    logic                        cancel_q;
    logic [NUM_REQ-1:0]          gnt_q;
    logic [NUM_REQ-1:0]          done_q;
    logic [NUM_REQ-1:0]          err_q;
    logic                        busy_q;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q;
    logic [31:0]                 pwdata_q;
    logic                        psel_q;
    logic                        penable_q;

    logic [31:0]                 cmp_a   [NUM_REQ];
    logic [2:0]                  presc_a [NUM_REQ];
    logic                        any_d;
    logic [IW-1:0]               win_d;
    logic [IW-1:0]               ptr_d;
    logic [31:0]                 ctrl_en;
    logic                        unused_irq0;

    assign unused_irq0 = timer_irq_i[0];
    assign ctrl_en     = {26'b0, presc_q, 2'b0, 1'b1};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cmp_a[i]   = cmp_i[32*i +: 32];
            presc_a[i] = presc_i[3*i +: 3];
        end
    end

    // First set request at or above the pointer, wrapping around
    always_comb begin
        any_d = 1'b0;
        win_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_d && req_i[IW'((int'(ptr_q) + k) % NUM_REQ)]) begin
                any_d = 1'b1;
                win_d = IW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        ptr_d = (win_d == IW'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_GAP;
            ptr_q     <= '0;
            idx_q     <= '0;
            cmp_q     <= '0;
            presc_q   <= '0;
            cancel_q  <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (any_d) begin
                        idx_q    <= win_d;
                        cmp_q    <= cmp_a[win_d];
                        presc_q  <= presc_a[win_d];
                        gnt_q    <= NUM_REQ'(1) << win_d;
                        ptr_q    <= ptr_d;
                        cancel_q <= 1'b0;
                        busy_q   <= 1'b1;
                        if (cmp_a[win_d] == 32'd0) begin
                            state_q <= S_ERR;
                            err_q   <= NUM_REQ'(1) << win_d;
                        end else begin
                            // DIS setup is presented straight from IDLE
                            state_q  <= S_DIS;
                            phase_q  <= PH_SETUP;
                            psel_q   <= 1'b1;
                            paddr_q  <= ADDR_CTRL;
                            pwdata_q <= '0;
                        end
                    end
                end
                S_DIS, S_CMP, S_EN, S_STOP: begin
                    unique case (phase_q)
                        PH_GAP: begin
                            psel_q   <= 1'b1;
                            phase_q  <= PH_SETUP;
                            paddr_q  <= (state_q == S_CMP) ? ADDR_CMP
                                                           : ADDR_CTRL;
                            pwdata_q <= (state_q == S_CMP) ? cmp_q
                                      : (state_q == S_EN)  ? ctrl_en
                                                           : '0;
                        end
                        PH_SETUP: begin
                            penable_q <= 1'b1;
                            phase_q   <= PH_ACC;
                        end
                        default: begin
                            if (PREADY) begin
                                psel_q    <= 1'b0;
                                penable_q <= 1'b0;
                                phase_q   <= PH_GAP;
                                if (state_q == S_DIS) begin
                                    state_q <= S_CMP;
                                end else if (state_q == S_CMP) begin
                                    state_q <= S_EN;
                                end else if (state_q == S_EN) begin
                                    state_q <= S_WAIT;
                                end else if (cancel_q) begin
                                    state_q <= S_IDLE;
                                    gnt_q   <= '0;
                                    busy_q  <= 1'b0;
                                end else begin
                                    state_q <= S_DONE;
                                    done_q  <= gnt_q;
                                end
                            end
                        end
                    endcase
                end
                S_WAIT: begin
                    // A match wins over a withdrawal seen in the same cycle
                    if (timer_irq_i[1] || !req_i[idx_q]) begin
                        cancel_q <= !timer_irq_i[1];
                        state_q  <= S_STOP;
                        phase_q  <= PH_SETUP;
                        psel_q   <= 1'b1;
                        paddr_q  <= ADDR_CTRL;
                        pwdata_q <= '0;
                    end
                end
                S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = psel_q;

endmodule

// File: tb/tb_timer_share_ctrl.sv
// tb_timer_share_ctrl: directed bench for timer_share_ctrl with a small
// behavioural APB timer slave and an APB write log.

module tb_timer_share_ctrl;

    localparam int N = 4;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic [N-1:0]      req_i = '0;
    logic [N*32-1:0]   cmp_i = '0;
    logic [N*3-1:0]    presc_i = '0;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      done_o;
    logic [N-1:0]      err_o;
    logic              busy_o;
    logic [11:0]       PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic              PREADY = 1'b1;
    logic [1:0]        timer_irq_i;

    int vecs = 0;
    int errs = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int psel_cnt = 0;

    logic [11:0] la [$];
    logic [31:0] ld [$];

    logic [31:0] t_timer;
    logic [31:0] t_cmp;
    logic [31:0] t_ctrl;
    logic [7:0]  t_pcnt;
    logic        force_irq = 1'b0;

    always #5 HCLK = ~HCLK;

    timer_share_ctrl #(
        .NUM_REQ(N),
        .APB_ADDR_WIDTH(12),
        .TIMER_BASE(12'h000)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .req_i(req_i),
        .cmp_i(cmp_i),
        .presc_i(presc_i),
        .gnt_o(gnt_o),
        .done_o(done_o),
        .err_o(err_o),
        .busy_o(busy_o),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PWRITE(PWRITE),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PREADY(PREADY),
        .timer_irq_i(timer_irq_i)
    );

    // Behavioural timer: counts up to CMP and holds there while enabled
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            t_timer <= '0;
            t_cmp   <= '0;
            t_ctrl  <= '0;
            t_pcnt  <= '0;
        end else if (PSEL && PENABLE && PREADY && PWRITE) begin
            if (PADDR == 12'h004) t_ctrl <= PWDATA;
            if (PADDR == 12'h008) begin
                t_cmp   <= PWDATA;
                t_timer <= '0;
                t_pcnt  <= '0;
            end
        end else if (t_ctrl[0] && t_timer != t_cmp) begin
            if (t_pcnt == (8'd1 << t_ctrl[5:3]) - 8'd1) begin
                t_pcnt  <= '0;
                t_timer <= t_timer + 1;
            end else begin
                t_pcnt <= t_pcnt + 8'd1;
            end
        end
    end

    assign timer_irq_i = {(t_ctrl[0] && t_timer == t_cmp) || force_irq, 1'b0};

    always @(posedge HCLK) begin
        if (HRESETn) begin
            if (PSEL && PENABLE && PREADY) begin
                la.push_back(PADDR);
                ld.push_back(PWDATA);
            end
            if (done_o != '0) done_cnt <= done_cnt + 1;
            if (err_o != '0)  err_cnt  <= err_cnt + 1;
            if (PSEL)         psel_cnt <= psel_cnt + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [31:0] c, input logic [2:0] p);
        cmp_i[32*i +: 32] = c;
        presc_i[3*i +: 3] = p;
    endtask

    task automatic wait_done(input int budget, output logic [N-1:0] d, output int cyc);
        d = '0;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge HCLK);
            cyc++;
            if (done_o != '0) begin
                d = done_o;
                req_i = req_i & ~done_o;
                break;
            end
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int c = 0;
        while (la.size() < n && c < budget) begin
            @(negedge HCLK);
            c++;
        end
        vecs++;
        if (la.size() < n) begin
            errs++;
            $display("FAIL %s log size %0d required %0d", nm, la.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int c = 0;
        while (busy_o !== 1'b0 && c < budget) begin
            @(negedge HCLK);
            c++;
        end
        vecs++;
        if (busy_o !== 1'b0) begin
            errs++;
            $display("FAIL %s busy_o=%b required 0", nm, busy_o);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        vecs++;
        if ({gnt_o, done_o, err_o, busy_o, PSEL, PENABLE, PWRITE} !== '0 ||
            PADDR !== 12'h0 || PWDATA !== 32'h0) begin
            errs++;
            $display("FAIL reset_outputs gnt=%b busy=%b psel=%b required 0",
                     gnt_o, busy_o, PSEL);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        vecs++;
        if (busy_o !== 1'b0 || gnt_o !== '0) begin
            errs++;
            $display("FAIL reset_idle busy=%b gnt=%b required 0", busy_o, gnt_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        int base;
        int c;
        int cyc;
        logic [N-1:0] d;
        logic [11:0] ea [4];
        logic [31:0] ed [4];
        ea = '{12'h004, 12'h008, 12'h004, 12'h004};
        ed = '{32'h0, 32'h5, 32'h1, 32'h0};
        base = la.size();
        set_req(0, 32'd1000, 3'd0);
        req_i = 4'b0001;
        wait_log(base + 3, 40, "t1_prog");
        repeat (2) @(negedge HCLK);
        vecs++;
        if (busy_o !== 1'b1 || PSEL !== 1'b0 || gnt_o !== 4'b0001) begin
            errs++;
            $display("FAIL t1_in_wait busy=%b psel=%b gnt=%b required 1 0 0001",
                     busy_o, PSEL, gnt_o);
        end
        #2 HRESETn = 1'b0;
        #1;
        vecs++;
        if ({gnt_o, done_o, err_o, busy_o, PSEL, PENABLE, PWRITE} !== '0 ||
            PADDR !== 12'h0 || PWDATA !== 32'h0) begin
            errs++;
            $display("FAIL t1_async_reset gnt=%b busy=%b psel=%b required 0",
                     gnt_o, busy_o, PSEL);
        end
        @(negedge HCLK);
        set_req(0, 32'd5, 3'd0);
        set_req(1, 32'd5, 3'd0);
        req_i = 4'b0011;
        base = la.size();
        HRESETn = 1'b1;
        c = 0;
        while (gnt_o == '0 && c < 10) begin
            @(negedge HCLK);
            c++;
        end
        vecs++;
        if (gnt_o !== 4'b0001) begin
            errs++;
            $display("FAIL t1_ptr_zero gnt=%b required 0001", gnt_o);
        end
        req_i = 4'b0001;
        wait_done(100, d, cyc);
        vecs++;
        if (d !== 4'b0001) begin
            errs++;
            $display("FAIL t1_done done=%b required 0001", d);
        end
        @(negedge HCLK);
        vecs++;
        if (la.size() !== base + 4) begin
            errs++;
            $display("FAIL t1_nwrites got %0d required 4", la.size() - base);
        end
        for (int k = 0; k < 4; k++) begin
            vecs++;
            if (la[base+k] !== ea[k] || ld[base+k] !== ed[k]) begin
                errs++;
                $display("FAIL t1_write%0d got %h<-%h required %h<-%h",
                         k, la[base+k], ld[base+k], ea[k], ed[k]);
            end
        end
    endtask

    task automatic test_done_latency();
        int dc0;
        int c;
        int cyc;
        logic [N-1:0] d;
        dc0 = done_cnt;
        set_req(0, 32'd5, 3'd0);
        req_i = 4'b0001;
        c = 0;
        while (!(timer_irq_i[1] && busy_o) && c < 100) begin
            @(negedge HCLK);
            c++;
        end
        vecs++;
        if (timer_irq_i[1] !== 1'b1) begin
            errs++;
            $display("FAIL t2_irq irq=%b required 1", timer_irq_i[1]);
        end
        wait_done(20, d, cyc);
        vecs++;
        if (d !== 4'b0001) begin
            errs++;
            $display("FAIL t2_done done=%b required 0001", d);
        end
        vecs++;
        if (cyc !== 3) begin
            errs++;
            $display("FAIL t2_latency got %0d cycles required 3", cyc);
        end
        @(negedge HCLK);
        vecs++;
        if (done_o !== '0) begin
            errs++;
            $display("FAIL t2_pulse_width done=%b required 0000", done_o);
        end
        repeat (4) @(negedge HCLK);
        vecs++;
        if (done_cnt - dc0 !== 1 || busy_o !== 1'b0) begin
            errs++;
            $display("FAIL t2_once dones=%0d busy=%b required 1 0",
                     done_cnt - dc0, busy_o);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g [5];
        logic [N-1:0] ge [5];
        logic [N-1:0] prev;
        int dn [N];
        int ng;
        int c;
        ge = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int j = 0; j < N; j++) dn[j] = 0;
        for (int k = 0; k < 5; k++) g[k] = '0;
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'd3, 3'd0);
        req_i = 4'b1111;
        prev = '0;
        ng = 0;
        c = 0;
        while (ng < 5 && c < 400) begin
            @(negedge HCLK);
            c++;
            if (gnt_o != '0 && prev == '0) begin
                g[ng] = gnt_o;
                ng++;
            end
            if (done_o != '0) begin
                vecs++;
                if (done_o !== gnt_o) begin
                    errs++;
                    $display("FAIL t3_done_gnt done=%b required %b", done_o, gnt_o);
                end
                for (int j = 0; j < N; j++) if (done_o[j]) dn[j]++;
            end
            prev = gnt_o;
        end
        req_i = '0;
        vecs++;
        if (ng !== 5) begin
            errs++;
            $display("FAIL t3_ngrants got %0d required 5", ng);
        end
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if (g[k] !== ge[k]) begin
                errs++;
                $display("FAIL t3_grant%0d got %b required %b", k, g[k], ge[k]);
            end
        end
        for (int j = 0; j < N; j++) begin
            vecs++;
            if (dn[j] !== 1) begin
                errs++;
                $display("FAIL t3_dones_req%0d got %0d required 1", j, dn[j]);
            end
        end
        wait_idle(60, "t3_idle");
    endtask

    task automatic test_err();
        int p0;
        int e0;
        p0 = psel_cnt;
        e0 = err_cnt;
        set_req(2, 32'd0, 3'd5);
        req_i = 4'b0100;
        @(negedge HCLK);
        vecs++;
        if (err_o !== 4'b0100 || gnt_o !== 4'b0100 || busy_o !== 1'b1 ||
            PSEL !== 1'b0) begin
            errs++;
            $display("FAIL t4_err err=%b gnt=%b busy=%b psel=%b required 0100 0100 1 0",
                     err_o, gnt_o, busy_o, PSEL);
        end
        req_i = '0;
        @(negedge HCLK);
        vecs++;
        if (err_o !== '0 || busy_o !== 1'b0 || gnt_o !== '0) begin
            errs++;
            $display("FAIL t4_release err=%b busy=%b gnt=%b required 0",
                     err_o, busy_o, gnt_o);
        end
        @(negedge HCLK);
        vecs++;
        if (psel_cnt !== p0 || err_cnt - e0 !== 1) begin
            errs++;
            $display("FAIL t4_no_apb psel_cycles=%0d errs=%0d required 0 1",
                     psel_cnt - p0, err_cnt - e0);
        end
    endtask

    task automatic test_withdraw();
        int base;
        int dc0;
        int ec0;
        base = la.size();
        dc0 = done_cnt;
        ec0 = err_cnt;
        set_req(1, 32'd1000, 3'd3);
        req_i = 4'b0010;
        wait_log(base + 3, 40, "t5_prog");
        vecs++;
        if (la[base+2] !== 12'h004 || ld[base+2] !== 32'h19) begin
            errs++;
            $display("FAIL t5_en_word got %h<-%h required 004<-00000019",
                     la[base+2], ld[base+2]);
        end
        repeat (3) @(negedge HCLK);
        req_i = '0;
        wait_idle(40, "t5_idle");
        @(negedge HCLK);
        vecs++;
        if (la.size() !== base + 4 || la[base+3] !== 12'h004 || ld[base+3] !== 32'h0) begin
            errs++;
            $display("FAIL t5_stop_write n=%0d last=%h<-%h required 4 004<-0",
                     la.size() - base, la[base+3], ld[base+3]);
        end
        vecs++;
        if (done_cnt !== dc0 || err_cnt !== ec0 || gnt_o !== '0) begin
            errs++;
            $display("FAIL t5_no_pulse dones=%0d errs=%0d gnt=%b required 0 0 0",
                     done_cnt - dc0, err_cnt - ec0, gnt_o);
        end
    endtask

    task automatic test_pready_stall();
        int base;
        int c;
        int cyc;
        logic [N-1:0] d;
        base = la.size();
        set_req(0, 32'd4, 3'd0);
        req_i = 4'b0001;
        c = 0;
        while (!(PSEL && !PENABLE && PADDR == 12'h008) && c < 20) begin
            @(negedge HCLK);
            c++;
        end
        vecs++;
        if (PSEL !== 1'b1 || PADDR !== 12'h008) begin
            errs++;
            $display("FAIL t6_cmp_setup psel=%b addr=%h required 1 008", PSEL, PADDR);
        end
        PREADY = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge HCLK);
            vecs++;
            if (PENABLE !== 1'b1 || PSEL !== 1'b1 || PADDR !== 12'h008 ||
                PWDATA !== 32'd4) begin
                errs++;
                $display("FAIL t6_access%0d en=%b sel=%b addr=%h data=%h required 1 1 008 4",
                         i, PENABLE, PSEL, PADDR, PWDATA);
            end
            if (i == 5) PREADY = 1'b1;
        end
        @(negedge HCLK);
        vecs++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
            errs++;
            $display("FAIL t6_release sel=%b en=%b required 0 0", PSEL, PENABLE);
        end
        wait_done(100, d, cyc);
        vecs++;
        if (d !== 4'b0001) begin
            errs++;
            $display("FAIL t6_done done=%b required 0001", d);
        end
        @(negedge HCLK);
        vecs++;
        if (la.size() !== base + 4 || ld[base+1] !== 32'd4) begin
            errs++;
            $display("FAIL t6_writes n=%0d cmp=%h required 4 4",
                     la.size() - base, ld[base+1]);
        end
    endtask

    task automatic test_irq_ignored();
        int base;
        int dc0;
        int c;
        int cyc;
        logic [N-1:0] d;
        logic [11:0] ea [4];
        logic [31:0] ed [4];
        ea = '{12'h004, 12'h008, 12'h004, 12'h004};
        ed = '{32'h0, 32'd12, 32'h1, 32'h0};
        base = la.size();
        dc0 = done_cnt;
        set_req(0, 32'd12, 3'd0);
        req_i = 4'b0001;
        c = 0;
        while (gnt_o == '0 && c < 10) begin
            @(negedge HCLK);
            c++;
        end
        force_irq = 1'b1;
        @(negedge HCLK);
        force_irq = 1'b0;
        c = 0;
        while (!(PSEL && !PENABLE && PADDR == 12'h008) && c < 20) begin
            @(negedge HCLK);
            c++;
        end
        force_irq = 1'b1;
        @(negedge HCLK);
        force_irq = 1'b0;
        vecs++;
        if (busy_o !== 1'b1 || done_cnt !== dc0 || la.size() !== base + 1) begin
            errs++;
            $display("FAIL t7_ignored busy=%b dones=%0d writes=%0d required 1 0 1",
                     busy_o, done_cnt - dc0, la.size() - base);
        end
        wait_done(200, d, cyc);
        vecs++;
        if (d !== 4'b0001 || t_timer !== 32'd12) begin
            errs++;
            $display("FAIL t7_done done=%b timer=%0d required 0001 12", d, t_timer);
        end
        @(negedge HCLK);
        for (int k = 0; k < 4; k++) begin
            vecs++;
            if (la[base+k] !== ea[k] || ld[base+k] !== ed[k]) begin
                errs++;
                $display("FAIL t7_write%0d got %h<-%h required %h<-%h",
                         k, la[base+k], ld[base+k], ea[k], ed[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_done_latency();
        test_round_robin();
        test_err();
        test_withdraw();
        test_pready_stall();
        test_irq_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
